digit_serial_adder: RTL and testbench
=====================================

Name: digit_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder computing result = num1 + num2 + c_in, DIGIT bits per clock, with one carry register rippling between digits.
- Companion to the combinational subtractor in the ALU datapath: performs the inverse operation and recovers a minuend from a difference.
- Issuing num2 = ~b with c_in = 1 produces a − b, giving a bit-exact cross-check of the subtractor.
- Valid/ready handshakes on both sides; trades latency for one small DIGIT-wide adder.

Parameters:
- WIDTH, 32, operand/result width in bits.
- DIGIT, 8, bits added per cycle. Must divide WIDTH. NUM_DIGITS = WIDTH/DIGIT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and c_in are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- num1  input  WIDTH  addend A, two's complement.
- num2  input  WIDTH  addend B, two's complement.
- c_in  input  1  carry into bit 0.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum bits [WIDTH-1:0].
- c_out  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset: rst high forces the following asynchronously:
  - state = IDLE, digit counter = 0, carry register = 0.
  - result = 0, c_out = 0, out_valid = 0, in_ready = 1.
  - Optional flags = 0.
  - No transfer is accepted while rst is high.
- FSM states: IDLE, RUN, DONE. State, counter, carry, and operand/result shift registers are all flops.
- IDLE:
  - in_ready = 1.
  - On a rising edge with in_valid = 1: latch num1/num2 into operand shift registers, carry <= c_in, count <= 0, go to RUN.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each cycle add the low DIGIT bits of both operands plus carry, giving a (DIGIT+1)-bit sum.
  - Shift the low DIGIT sum bits into the top of the result register; carry <= sum MSB.
  - Shift both operands right by DIGIT; count++.
  - On the edge where count == NUM_DIGITS-1: go to DONE and drive c_out from the final carry.
- DONE:
  - out_valid = 1.
  - result, c_out and flags are held stable while out_ready = 0.
  - On a rising edge with out_ready = 1: go to IDLE; out_valid drops the next cycle.
  - result and c_out keep their last value in IDLE; they are don't-care when out_valid = 0.
- Latency: out_valid rises exactly NUM_DIGITS clocks after the accepting edge (4 cycles at defaults).
- Throughput: one operation per NUM_DIGITS + 2 cycles minimum, because there is no input/output overlap.
- in_valid while not in IDLE is ignored; operands are never re-sampled mid-operation.
- out_ready while out_valid = 0 is ignored.
- Arithmetic is modulo 2^WIDTH; the carry is unsigned and never sign-extended.
- Edge cases:
  - DIGIT == WIDTH is legal: single RUN cycle.
  - Counter width is clog2(NUM_DIGITS), minimum 1 bit.
- Reset mid-operation (RUN or DONE): aborts immediately to reset values. The partial result is discarded and nothing is reported.

Optional Feature:
- Macro: DIGIT_SERIAL_ADDER_FLAGS_EN.
- When defined, add three ports, all registered, all updated at the RUN->DONE transition, all reset to 0, all held in DONE:
  - overflow  output  1: carry into bit WIDTH-1 XOR c_out. This needs the carry into the MSB to be tapped during the final digit.
  - zero  output  1: result == 0.
  - negative  output  1: result[WIDTH-1].
- When undefined: these ports and their logic do not exist. Port list as above.

Test Plan:
- num1=0x00000005, num2=0x00000003, c_in=0 -> result=0x00000008, c_out=0; out_valid exactly 4 cycles after the accept edge.
- num1=0xFFFFFFFF, num2=0x00000001, c_in=0 -> result=0x00000000, c_out=1; with FLAGS_EN: zero=1, overflow=0, negative=0.
- num1=0x7FFFFFFF, num2=0x00000001, c_in=0 -> result=0x80000000, c_out=0; with FLAGS_EN: overflow=1, negative=1.
- Subtract-via-adder cross-check: num1=0x0000000A, num2=0xFFFFFFFC (~3), c_in=1 -> result=0x00000007, c_out=1, matching the subtractor for 10−3.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/c_out stable, in_ready=0, and a pulsed in_valid with new operands is ignored. After out_ready=1, the next accepted op computes correctly.
- Assert rst during the 2nd RUN cycle -> out_valid=0, result=0, c_out=0, in_ready=1 immediately. The next op 0x12345678+0x11111111 -> 0x23456789, c_out=0.

Source files
------------

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle WIDTH-bit adder that adds DIGIT bits per
// clock with one carry flop rippling between digits. result = num1+num2+c_in
// (modulo 2^WIDTH), c_out is the carry out of bit WIDTH-1.
// Issuing num2 = ~b with c_in = 1 yields a - b, which cross-checks the
// combinational subtractor in the ALU datapath.
// Optional feature macro: DIGIT_SERIAL_ADDER_FLAGS_EN adds registered
// overflow / zero / negative outputs captured at the end of the last digit.
module digit_serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
    output logic             overflow,
    output logic             zero,
    output logic             negative,
`endif
    output logic             c_out
);

    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               carry_r;
    logic [WIDTH-1:0]   op_a_r;
    logic [WIDTH-1:0]   op_b_r;
    logic [WIDTH-1:0]   res_r;
    logic               c_out_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               in_ready_s;
    logic               out_valid_s;
    logic [DIGIT:0]     digit_sum_s;
    logic [WIDTH-1:0]   res_shift_s;
    logic               last_digit_s;
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
    logic               overflow_r;
    logic               zero_r;
    logic               negative_r;
    logic               msb_carry_in_s;
`endif

    // The one small adder: low digit of each operand plus the rippling carry.
    assign digit_sum_s  = {1'b0, op_a_r[DIGIT-1:0]} + {1'b0, op_b_r[DIGIT-1:0]}
                        + {{DIGIT{1'b0}}, carry_r};
    assign last_digit_s = (cnt_r == LAST_CNT);

    // New digit enters at the top, so after NUM_DIGITS shifts digit 0 sits at the bottom.
    generate
        if (NUM_DIGITS == 1) begin : g_single_digit
            assign res_shift_s = digit_sum_s[DIGIT-1:0];
        end else begin : g_multi_digit
            assign res_shift_s = {digit_sum_s[DIGIT-1:0], res_r[WIDTH-1:DIGIT]};
        end
    endgenerate

`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
    // In the final digit, the sum bit is a^b^cin, so the carry into the MSB is recoverable.
    assign msb_carry_in_s = op_a_r[DIGIT-1] ^ op_b_r[DIGIT-1] ^ digit_sum_s[DIGIT-1];
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: accept in IDLE, run NUM_DIGITS cycles, hold until consumed.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_s = ST_RUN;
                else          state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_digit_s) state_s = ST_DONE;
                else              state_s = ST_RUN;
            end
            ST_DONE: begin
                if (out_ready) state_s = ST_IDLE;
                else           state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the handshake flops line up with the state.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        if (state_s == ST_IDLE) begin
            in_ready_s = 1'b1;
        end else if (state_s == ST_DONE) begin
            out_valid_s = 1'b1;
        end else begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
        end
    end

    // Handshake output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
        end
    end

    // Datapath: load operands on accept, shift one digit per RUN cycle, freeze otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= {CNT_W{1'b0}};
            carry_r    <= 1'b0;
            op_a_r     <= {WIDTH{1'b0}};
            op_b_r     <= {WIDTH{1'b0}};
            res_r      <= {WIDTH{1'b0}};
            c_out_r    <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
            negative_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_a_r  <= num1;
                        op_b_r  <= num2;
                        carry_r <= c_in;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    op_a_r  <= op_a_r >> DIGIT;
                    op_b_r  <= op_b_r >> DIGIT;
                    res_r   <= res_shift_s;
                    carry_r <= digit_sum_s[DIGIT];
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (last_digit_s) begin
                        c_out_r    <= digit_sum_s[DIGIT];
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
                        overflow_r <= msb_carry_in_s ^ digit_sum_s[DIGIT];
                        zero_r     <= (res_shift_s == {WIDTH{1'b0}});
                        negative_r <= digit_sum_s[DIGIT-1];
`endif
                    end
                end
                ST_DONE: begin
                    // Hold result and flags until the consumer takes them.
                end
                default: begin
                    // Unreachable encoding; the next-state logic returns to IDLE.
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = res_r;
    assign c_out     = c_out_r;
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
    assign overflow  = overflow_r;
    assign zero      = zero_r;
    assign negative  = negative_r;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: directed vectors, random
// operands against an arithmetic reference, backpressure, mid-operation
// reset and back-to-back throughput.
module tb_digit_serial_adder;

    localparam int WIDTH      = 32;
    localparam int DIGIT      = 8;
    localparam int NUM_DIGITS = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
    logic             overflow;
    logic             zero;
    logic             negative;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num1      (num1),
        .num2      (num2),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
`endif
        .c_out     (c_out)
    );

    always #5 clk = ~clk;

    // Reference: plain wide addition, carry is bit WIDTH.
    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic ci);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operation, then count edges until out_valid (bounded).
    task automatic issue_and_wait(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic ci, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        num1 = a; num2 = b; c_in = ci; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        num1 = $urandom; num2 = $urandom; c_in = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        num1 = '0; num2 = '0; c_in = 1'b0;
        step(); step();
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_checks++;
        if (result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result); else n_pass++;
        n_checks++;
        if (c_out !== 1'b0) $display("FAIL reset_c_out: got %b expected 0", c_out); else n_pass++;
        n_checks++;
        rst = 1'b0;
        step();
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL post_reset_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] ta [3] = '{32'h00000005, 32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [WIDTH-1:0] tb [3] = '{32'h00000003, 32'h00000001, 32'h00000001};
        logic [WIDTH-1:0] er [3] = '{32'h00000008, 32'h00000000, 32'h80000000};
        logic             ec [3] = '{1'b0, 1'b1, 1'b0};
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
        logic             ez [3] = '{1'b0, 1'b1, 1'b0};
        logic             eo [3] = '{1'b0, 1'b0, 1'b1};
        logic             en [3] = '{1'b0, 1'b0, 1'b1};
`endif
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue_and_wait(ta[i], tb[i], 1'b0, lat);
            if (lat !== NUM_DIGITS) $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, NUM_DIGITS); else n_pass++;
            n_checks++;
            if (result !== er[i]) $display("FAIL dir_result[%0d]: got %h expected %h", i, result, er[i]); else n_pass++;
            n_checks++;
            if (c_out !== ec[i]) $display("FAIL dir_c_out[%0d]: got %b expected %b", i, c_out, ec[i]); else n_pass++;
            n_checks++;
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
            if (zero !== ez[i] || overflow !== eo[i] || negative !== en[i])
                $display("FAIL dir_flags[%0d]: got z/o/n=%b%b%b expected %b%b%b", i, zero, overflow, negative, ez[i], eo[i], en[i]);
            else n_pass++;
            n_checks++;
`endif
            release_result();
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL dir_release[%0d]: got out_valid=%b in_ready=%b expected 0/1", i, out_valid, in_ready);
            else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_subtract();
        int lat;
        issue_and_wait(32'h0000000A, 32'hFFFFFFFC, 1'b1, lat);
        if (result !== 32'h00000007) $display("FAIL sub_result: got %h expected 00000007", result); else n_pass++;
        n_checks++;
        if (c_out !== 1'b1) $display("FAIL sub_c_out: got %b expected 1", c_out); else n_pass++;
        n_checks++;
        release_result();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        logic             ci;
        logic [WIDTH:0]   exp;
        int               lat;
        for (int i = 0; i < 30; i++) begin
            a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
            if (i == 0) b = ~a;
            exp = ref_add(a, b, ci);
            issue_and_wait(a, b, ci, lat);
            if (lat !== NUM_DIGITS) $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, NUM_DIGITS); else n_pass++;
            n_checks++;
            if (result !== exp[WIDTH-1:0] || c_out !== exp[WIDTH])
                $display("FAIL rnd_sum[%0d]: %h+%h+%b got %b_%h expected %b_%h", i, a, b, ci, c_out, result, exp[WIDTH], exp[WIDTH-1:0]);
            else n_pass++;
            n_checks++;
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
            if (zero !== (exp[WIDTH-1:0] == '0) || negative !== exp[WIDTH-1]
                || overflow !== ((a[WIDTH-1] == b[WIDTH-1]) && (exp[WIDTH-1] != a[WIDTH-1])))
                $display("FAIL rnd_flags[%0d]: got z/o/n=%b%b%b for sum %h", i, zero, overflow, negative, exp[WIDTH-1:0]);
            else n_pass++;
            n_checks++;
`endif
            release_result();
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] a, b;
        logic [WIDTH:0]   exp;
        int               lat;
        a = $urandom; b = $urandom;
        exp = ref_add(a, b, 1'b0);
        issue_and_wait(a, b, 1'b0, lat);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                num1 = ~a; num2 = a; c_in = 1'b1; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (result !== exp[WIDTH-1:0] || c_out !== exp[WIDTH])
                $display("FAIL bp_hold[%0d]: got %b_%h expected %b_%h", k, c_out, result, exp[WIDTH], exp[WIDTH-1:0]);
            else n_pass++;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1)
                $display("FAIL bp_handshake[%0d]: got in_ready=%b out_valid=%b expected 0/1", k, in_ready, out_valid);
            else n_pass++;
            n_checks++;
        end
        release_result();
        a = $urandom; b = $urandom;
        exp = ref_add(a, b, 1'b1);
        issue_and_wait(a, b, 1'b1, lat);
        if (result !== exp[WIDTH-1:0] || c_out !== exp[WIDTH])
            $display("FAIL bp_next_op: got %b_%h expected %b_%h", c_out, result, exp[WIDTH], exp[WIDTH-1:0]);
        else n_pass++;
        n_checks++;
        release_result();
    endtask

    task automatic test_reset_midop();
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        num1 = 32'hDEADBEEF; num2 = 32'h01234567; c_in = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL midrst_handshake: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        else n_pass++;
        n_checks++;
        if (result !== 32'h0 || c_out !== 1'b0)
            $display("FAIL midrst_outputs: got %b_%h expected 0_00000000", c_out, result);
        else n_pass++;
        n_checks++;
        step();
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (out_valid) n++;
        end
        if (n !== 0) $display("FAIL midrst_no_report: got %0d valid cycles expected 0", n); else n_pass++;
        n_checks++;
        issue_and_wait(32'h12345678, 32'h11111111, 1'b0, lat);
        if (result !== 32'h23456789 || c_out !== 1'b0)
            $display("FAIL midrst_next_op: got %b_%h expected 0_23456789", c_out, result);
        else n_pass++;
        n_checks++;
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH:0]   exp_q [$];
        logic [WIDTH:0]   exp;
        logic [WIDTH-1:0] a, b;
        logic             ci;
        int               last_t;
        last_t = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 70; cyc++) begin
            if (in_ready) begin
                if (cyc < 40) begin
                    a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
                    num1 = a; num2 = b; c_in = ci; in_valid = 1'b1;
                    exp_q.push_back(ref_add(a, b, ci));
                end else begin
                    in_valid = 1'b0;
                end
            end
            step();
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra: got result %h with nothing outstanding expected none", result);
                end else begin
                    exp = exp_q.pop_front();
                    if (result !== exp[WIDTH-1:0] || c_out !== exp[WIDTH])
                        $display("FAIL b2b_sum: got %b_%h expected %b_%h", c_out, result, exp[WIDTH], exp[WIDTH-1:0]);
                    else n_pass++;
                end
                n_checks++;
                if (last_t >= 0) begin
                    if (cyc - last_t !== NUM_DIGITS + 2)
                        $display("FAIL b2b_period: got %0d expected %0d", cyc - last_t, NUM_DIGITS + 2);
                    else n_pass++;
                    n_checks++;
                end
                last_t = cyc;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        if (exp_q.size() !== 0) $display("FAIL b2b_drain: got %0d outstanding expected 0", exp_q.size()); else n_pass++;
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_subtract();
        test_random();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
